// File: rtl/seg_scan_controller.sv
// Time-multiplexed scan controller for a common-anode 7-segment display with
// double-buffered value updates. Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan_controller #(
  parameter int NUM_DIGITS = 4,
  parameter int ON_CYCLES  = 50000,
  parameter int GAP_CYCLES = 500
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  output logic                      ready,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [3:0]                hex_digit,
  output logic                      blank,
  output logic                      dp_n
);

  localparam int MAXC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);

  typedef enum logic {S_GAP, S_ON} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]   disp_val_q, disp_val_d, pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]     disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic                      ready_q, ready_d;
  logic [NUM_DIGITS-1:0]     an_q, an_d;
  logic [3:0]                hex_q, hex_d;
  logic                      blank_q, blank_d;
  logic                      dp_n_q, dp_n_d;

  logic                      gap_done, on_done, commit;
  logic [4*NUM_DIGITS-1:0]   src_val;
  logic [NUM_DIGITS-1:0]     src_dp;
  logic [3:0]                nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]     sel;
  logic                      lzb_hide;

  assign gap_done = (cnt_q == CW'(GAP_CYCLES - 1));
  assign on_done  = (cnt_q == CW'(ON_CYCLES - 1));
  assign commit   = (state_q == S_GAP) && gap_done && (idx_q == '0) && !ready_q;

  // The slot entered on a commit edge must already show the newly committed data.
  assign src_val = commit ? pend_val_q : disp_val_q;
  assign src_dp  = commit ? pend_dp_q  : disp_dp_q;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nib[gi] = src_val[gi*4 +: 4];
      assign sel[gi] = (idx_q == IW'(gi));
    end
  endgenerate

`ifdef SEG_SCAN_LZB_EN
  logic [NUM_DIGITS-1:0] upper_zero;
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
      if (gi == NUM_DIGITS - 1) begin : g_top
        assign upper_zero[gi] = (nib[gi] == 4'h0);
      end else begin : g_chain
        assign upper_zero[gi] = (nib[gi] == 4'h0) && upper_zero[gi+1];
      end
    end
  endgenerate
  assign lzb_hide = (idx_q != '0) && upper_zero[idx_q] && !src_dp[idx_q];
`else
  assign lzb_hide = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    ready_d    = ready_q;
    an_d       = an_q;
    hex_d      = hex_q;
    blank_d    = blank_q;
    dp_n_d     = dp_n_q;

    case (state_q)
      S_GAP: begin
        if (gap_done) begin
          state_d = S_ON;
          cnt_d   = '0;
          an_d    = ~sel;
          hex_d   = nib[idx_q];
          dp_n_d  = ~src_dp[idx_q];
          blank_d = 1'b0;
          if (lzb_hide) begin
            an_d    = '1;
            blank_d = 1'b1;
            dp_n_d  = 1'b1;
          end
        end
      end
      S_ON: begin
        if (on_done) begin
          state_d = S_GAP;
          cnt_d   = '0;
          idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
          an_d    = '1;
          blank_d = 1'b1;
          dp_n_d  = 1'b1;
        end
      end
      default: state_d = S_GAP;
    endcase

    if (commit) begin
      disp_val_d = pend_val_q;
      disp_dp_d  = pend_dp_q;
      ready_d    = 1'b1;
    end
    // A load on the commit edge is captured but keeps ready low for the next frame.
    if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp_in;
      ready_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_GAP;
      cnt_q      <= '0;
      idx_q      <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      ready_q    <= 1'b1;
      an_q       <= '1;
      hex_q      <= 4'h0;
      blank_q    <= 1'b1;
      dp_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      ready_q    <= ready_d;
      an_q       <= an_d;
      hex_q      <= hex_d;
      blank_q    <= blank_d;
      dp_n_q     <= dp_n_d;
    end
  end

  assign ready     = ready_q;
  assign an        = an_q;
  assign hex_digit = hex_q;
  assign blank     = blank_q;
  assign dp_n      = dp_n_q;

endmodule
